// File: rtl/conv_stream_pkg.sv
// Shared types and constants for the convolution result streamer:
// FSM state encoding, pixel/checksum widths and the address-width helper.
package conv_stream_pkg;

  localparam int PIXEL_W    = 8;
  localparam int CHECKSUM_W = 16;

  typedef enum logic {
    CAPTURE = 1'b0,
    STREAM  = 1'b1
  } state_t;

  // Width needed to address 'depth' entries; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_result_streamer_if.sv
// Valid/ready byte stream carrying the replayed frame toward the host side.
interface conv_result_streamer_if;
  import conv_stream_pkg::*;

  logic               m_valid;
  logic               m_ready;
  logic [PIXEL_W-1:0] m_data;
  logic               m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/conv_result_streamer_frame_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port
// (1-cycle latency). Written so that it maps onto block RAM.
module frame_ram #(
  parameter int DEPTH  = 65536,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: no reset on the array or read register; a reset would stop RAM inference.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures the convolution engine's output frame, then replays it in raster
// order on a valid/ready stream. Optional macro: CONV_STREAMER_CHECKSUM_EN.
module conv_result_streamer
  import conv_stream_pkg::*;
#(
  parameter  int IMAGE_WIDTH  = 256,
  parameter  int IMAGE_HEIGHT = 256,
  localparam int DEPTH        = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int ADDR_W       = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  output_we,
  input  logic [ADDR_W-1:0]     output_addr,
  input  logic [PIXEL_W-1:0]    pixel_out,
  input  logic                  done,
  conv_result_streamer_if.master m_if,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [CHECKSUM_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(DEPTH);

  state_t             r_state, w_state_nxt;
  logic               r_done_q;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_all_issued;
  logic               r_pend, r_pend_last;
  logic [1:0]         r_cnt;
  logic [PIXEL_W-1:0] r_q0_data, r_q1_data;
  logic               r_q0_last, r_q1_last;
  logic               r_frame_done, r_overrun;
  logic [PIXEL_W-1:0] w_ram_q;
  logic               w_start, w_wr_en, w_pop, w_last_xfer, w_issue;
  logic [2:0]         w_occ;

  assign w_start     = done & ~r_done_q & (r_state == CAPTURE);
  assign w_wr_en     = output_we & (r_state == CAPTURE) & ({1'b0, output_addr} < ADDR_LIM);
  assign w_pop       = (r_cnt != 2'd0) & m_if.m_ready;
  assign w_last_xfer = w_pop & r_q0_last;
  // Reads are only issued when the two-entry skid is guaranteed room for them.
  assign w_occ       = {1'b0, r_cnt} + {2'b0, r_pend} - {2'b0, w_pop};
  assign w_issue     = (r_state == STREAM) & ~r_all_issued & (w_occ < 3'd2);

  frame_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(PIXEL_W)) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (output_addr),
    .i_wr_data (pixel_out),
    .i_rd_en   (w_issue),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CAPTURE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CAPTURE: if (w_start)     w_state_nxt = STREAM;
      STREAM:  if (w_last_xfer) w_state_nxt = CAPTURE;
      default: w_state_nxt = CAPTURE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q     <= 1'b0;
      r_rd_addr    <= '0;
      r_all_issued <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done_q     <= done;
      r_pend       <= w_issue;
      r_frame_done <= w_last_xfer;
      if (w_issue) begin
        r_pend_last  <= (r_rd_addr == LAST_ADDR);
        r_all_issued <= (r_rd_addr == LAST_ADDR);
        r_rd_addr    <= r_rd_addr + ADDR_W'(1);
      end
      if (w_last_xfer) begin
        r_rd_addr    <= '0;
        r_all_issued <= 1'b0;
      end
      if (w_start)                               r_overrun <= 1'b0;
      else if (output_we && r_state == STREAM)   r_overrun <= 1'b1;
    end
  end

  // Two-entry output skid: q0 is the presented beat, q1 absorbs the read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_q0_data <= '0;
      r_q0_last <= 1'b0;
      r_q1_data <= '0;
      r_q1_last <= 1'b0;
    end else begin
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
      if (r_pend) begin
        if ((w_pop && r_cnt == 2'd1) || (!w_pop && r_cnt == 2'd0)) begin
          r_q0_data <= w_ram_q;
          r_q0_last <= r_pend_last;
        end else begin
          if (w_pop) begin
            r_q0_data <= r_q1_data;
            r_q0_last <= r_q1_last;
          end
          r_q1_data <= w_ram_q;
          r_q1_last <= r_pend_last;
        end
      end else if (w_pop && r_cnt == 2'd2) begin
        r_q0_data <= r_q1_data;
        r_q0_last <= r_q1_last;
      end
    end
  end

  assign m_if.m_valid = (r_cnt != 2'd0);
  assign m_if.m_data  = r_q0_data;
  assign m_if.m_last  = r_q0_last & (r_cnt != 2'd0);
  assign busy         = (r_state == STREAM);
  assign frame_done   = r_frame_done;
  assign overrun      = r_overrun;

`ifdef CONV_STREAMER_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] r_acc, r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else begin
      if (w_start)    r_acc <= '0;
      else if (w_pop) r_acc <= r_acc + CHECKSUM_W'(r_q0_data);
      if (w_last_xfer) r_checksum <= r_acc + CHECKSUM_W'(r_q0_data);
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer on a 4x4 frame with a
// behavioural frame-buffer model and randomized pixels and backpressure.
module tb_conv_result_streamer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          output_we;
  logic [AW-1:0] output_addr;
  logic [7:0]    pixel_out;
  logic          done;
  logic          busy, frame_done, overrun;
  logic [15:0]   checksum;

  conv_result_streamer_if s_if ();

  conv_result_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .output_we   (output_we),
    .output_addr (output_addr),
    .pixel_out   (pixel_out),
    .done        (done),
    .m_if        (s_if),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_mem [N];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(exp_mem[i]);
    return 16'(s);
  endfunction

  function automatic logic [15:0] exp_checksum();
`ifdef CONV_STREAMER_CHECKSUM_EN
    return model_sum();
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_reset_values();
    check("rst_m_valid", s_if.m_valid, 0);
    check("rst_m_data", s_if.m_data, 0);
    check("rst_m_last", s_if.m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_checksum", checksum, 0);
  endtask

  task automatic write_px(input int addr, input logic [7:0] data);
    output_we   = 1'b1;
    output_addr = AW'(addr);
    pixel_out   = data;
    exp_mem[addr] = data;
    @(posedge clk); #1;
    output_we = 1'b0;
  endtask

  // Raise done (optionally with a coincident write) and check start latency.
  task automatic start_frame(input bit wr, input int waddr, input logic [7:0] wdata, input bit hold);
    s_if.m_ready = 1'b0;
    done = 1'b1;
    if (wr) begin
      output_we   = 1'b1;
      output_addr = AW'(waddr);
      pixel_out   = wdata;
      exp_mem[waddr] = wdata;
    end
    @(posedge clk); #1;
    output_we = 1'b0;
    if (!hold) done = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_lat_1", s_if.m_valid, 0);
    check("overrun_cleared", overrun, 0);
    @(posedge clk); #1;
    check("valid_lat_2", s_if.m_valid, 0);
    @(posedge clk); #1;
    check("valid_lat_3", s_if.m_valid, 1);
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic recv(input int mode, input int n_beats);
    int beat = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held_data;
    logic held_last;
    while (beat < n_beats && cyc < 300) begin
      if (stalled) begin
        check("stall_valid", s_if.m_valid, 1);
        check("stall_data", s_if.m_data, held_data);
        check("stall_last", s_if.m_last, held_last);
      end
      case (mode)
        0:       s_if.m_ready = 1'b1;
        1:       s_if.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: s_if.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (s_if.m_valid && s_if.m_ready) begin
        check("beat_data", s_if.m_data, exp_mem[beat]);
        check("beat_last", s_if.m_last, (beat == N - 1));
        beat++;
        stalled = 1'b0;
      end else if (s_if.m_valid) begin
        held_data = s_if.m_data;
        held_last = s_if.m_last;
        stalled   = 1'b1;
      end else if (mode == 0 && beat > 0) begin
        check("no_bubble", s_if.m_valid, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("recv_beats", beat, n_beats);
    s_if.m_ready = 1'b0;
  endtask

  task automatic check_end();
    check("frame_done_pulse", frame_done, 1);
    check("busy_low_at_done", busy, 0);
    check("valid_low_at_done", s_if.m_valid, 0);
    check("checksum", checksum, exp_checksum());
    @(posedge clk); #1;
    check("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    rst          = 1'b1;
    done         = 1'b0;
    output_we    = 1'b0;
    output_addr  = '0;
    pixel_out    = '0;
    s_if.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, full-rate stream.
    for (int a = 0; a < N; a++) write_px(a, 8'(a));
    start_frame(1'b0, 0, 8'h00, 1'b0);
    recv(0, N);
    check_end();

    // Same frame under 1,0,0,1 backpressure.
    start_frame(1'b0, 0, 8'h00, 1'b0);
    recv(1, N);
    check_end();

    // Random frame with overwrites; final write lands on the start edge.
    for (int a = 0; a < N; a++) write_px(a, 8'($urandom));
    for (int k = 0; k < 20; k++) write_px(int'($urandom_range(0, N - 1)), 8'($urandom));
    start_frame(1'b1, N - 1, 8'($urandom), 1'b0);
    recv(2, N);
    check_end();

    // Write during streaming is dropped and flagged.
    start_frame(1'b0, 0, 8'h00, 1'b0);
    output_we   = 1'b1;
    output_addr = AW'($urandom_range(0, N - 1));
    pixel_out   = ~exp_mem[output_addr];
    @(posedge clk); #1;
    output_we = 1'b0;
    check("overrun_set", overrun, 1);
    recv(2, N);
    check_end();
    check("overrun_sticky", overrun, 1);

    // done held high for 40 cycles streams one frame only.
    start_frame(1'b0, 0, 8'h00, 1'b1);
    recv(0, N);
    check_end();
    for (int c = 0; c < 40 - N - 6; c++) begin
      check("held_done_no_restart", s_if.m_valid | busy, 0);
      @(posedge clk); #1;
    end
    done = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-stream, then a clean replay from address 0.
    start_frame(1'b0, 0, 8'h00, 1'b0);
    recv(0, 7);
    #2 rst = 1'b1;
    #1 check_reset_values();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_frame(1'b0, 0, 8'h00, 1'b0);
    recv(2, N);
    check_end();

    // All-0xFF frame checksum.
    for (int a = 0; a < N; a++) write_px(a, 8'hFF);
    start_frame(1'b0, 0, 8'h00, 1'b0);
    recv(0, N);
`ifdef CONV_STREAMER_CHECKSUM_EN
    check("checksum_ff_frame", checksum, 16'h0FF0);
`else
    check("checksum_disabled", checksum, 16'h0000);
`endif
    check_end();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
